// File: rtl/axi_dma_rd_desc_split.sv
// Splits one large read request into CHUNK_SIZE-aligned descriptors for
// axi_dma_rd, limits issued-but-uncompleted descriptors to MAX_OUTSTANDING,
// and reports a single completion once every piece has come back.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   s_axis_req_*              parent request (addr, len, tag, id, dest, user, valid/ready)
//   m_axis_read_desc_*        sub-descriptors to axi_dma_rd (valid/ready)
//   s_axis_read_desc_status_* per-descriptor completions from axi_dma_rd
//   m_axis_req_status_*       single-cycle parent completion pulse
//   busy                      request in progress
module axi_dma_rd_desc_split #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned LEN_WIDTH       = 20,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned AXIS_ID_WIDTH   = 8,
    parameter int unsigned AXIS_DEST_WIDTH = 8,
    parameter int unsigned AXIS_USER_WIDTH = 1,
    parameter int unsigned CHUNK_SIZE      = 256,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [ADDR_WIDTH-1:0]      s_axis_req_addr,
    input  logic [LEN_WIDTH-1:0]       s_axis_req_len,
    input  logic [TAG_WIDTH-1:0]       s_axis_req_tag,
    input  logic [AXIS_ID_WIDTH-1:0]   s_axis_req_id,
    input  logic [AXIS_DEST_WIDTH-1:0] s_axis_req_dest,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_req_user,
    input  logic                       s_axis_req_valid,
    output logic                       s_axis_req_ready,

    output logic [ADDR_WIDTH-1:0]      m_axis_read_desc_addr,
    output logic [LEN_WIDTH-1:0]       m_axis_read_desc_len,
    output logic [TAG_WIDTH-1:0]       m_axis_read_desc_tag,
    output logic [AXIS_ID_WIDTH-1:0]   m_axis_read_desc_id,
    output logic [AXIS_DEST_WIDTH-1:0] m_axis_read_desc_dest,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_read_desc_user,
    output logic                       m_axis_read_desc_valid,
    input  logic                       m_axis_read_desc_ready,

    input  logic [TAG_WIDTH-1:0]       s_axis_read_desc_status_tag,
    input  logic                       s_axis_read_desc_status_valid,

    output logic [TAG_WIDTH-1:0]       m_axis_req_status_tag,
    output logic                       m_axis_req_status_valid,
    output logic                       busy
);

    localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]       remaining_q, remaining_d;
    logic [OUT_WIDTH-1:0]       outstanding_q, outstanding_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;
    logic [AXIS_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d;
    logic [AXIS_USER_WIDTH-1:0] user_q, user_d;
    logic [ADDR_WIDTH-1:0]      desc_addr_q, desc_addr_d;
    logic [LEN_WIDTH-1:0]       desc_len_q, desc_len_d;
    logic                       desc_valid_q, desc_valid_d;
    logic                       req_ready_q, req_ready_d;
    logic                       status_valid_q, status_valid_d;
    logic [TAG_WIDTH-1:0]       status_tag_q, status_tag_d;
    logic                       busy_q, busy_d;

    logic [LEN_WIDTH-1:0]       offset, room, chunk;
    logic                       desc_hs, status_dec;

    // Completion tags are not checked: completions are only counted.
    logic                       unused_status_tag;
    assign unused_status_tag = ^s_axis_read_desc_status_tag;

    // Largest piece that stays inside the current CHUNK_SIZE-aligned window
    always_comb begin
        offset = LEN_WIDTH'(cur_addr_q & ADDR_WIDTH'(CHUNK_SIZE - 1));
        room   = LEN_WIDTH'(CHUNK_SIZE) - offset;
        chunk  = (remaining_q < room) ? remaining_q : room;
    end

    // In-flight descriptor count; a completion with nothing in flight is dropped
    always_comb begin
        desc_hs       = desc_valid_q && m_axis_read_desc_ready;
        status_dec    = s_axis_read_desc_status_valid && (outstanding_q != '0);
        outstanding_d = outstanding_q;
        if (desc_hs && !status_dec) begin
            outstanding_d = outstanding_q + OUT_WIDTH'(1);
        end else if (!desc_hs && status_dec) begin
            outstanding_d = outstanding_q - OUT_WIDTH'(1);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        remaining_d    = remaining_q;
        tag_d          = tag_q;
        id_d           = id_q;
        dest_d         = dest_q;
        user_d         = user_q;
        desc_addr_d    = desc_addr_q;
        desc_len_d     = desc_len_q;
        desc_valid_d   = desc_valid_q;
        status_valid_d = 1'b0;
        status_tag_d   = status_tag_q;

        case (state_q)
            IDLE: begin
                if (s_axis_req_valid && req_ready_q) begin
                    cur_addr_d  = s_axis_req_addr;
                    remaining_d = s_axis_req_len;
                    tag_d       = s_axis_req_tag;
                    id_d        = s_axis_req_id;
                    dest_d      = s_axis_req_dest;
                    user_d      = s_axis_req_user;
                    state_d     = (s_axis_req_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (desc_valid_q) begin
                    if (m_axis_read_desc_ready) begin
                        // Address may wrap past the top of the address space
                        cur_addr_d   = cur_addr_q + ADDR_WIDTH'(desc_len_q);
                        remaining_d  = remaining_q - desc_len_q;
                        desc_valid_d = 1'b0;
                        if (remaining_q == desc_len_q) begin
                            state_d = WAIT;
                        end
                    end
                end else if (outstanding_q < OUT_WIDTH'(MAX_OUTSTANDING)) begin
                    desc_addr_d  = cur_addr_q;
                    desc_len_d   = chunk;
                    desc_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (outstanding_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                status_valid_d = 1'b1;
                status_tag_d   = tag_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cur_addr_q     <= '0;
            remaining_q    <= '0;
            outstanding_q  <= '0;
            tag_q          <= '0;
            id_q           <= '0;
            dest_q         <= '0;
            user_q         <= '0;
            desc_addr_q    <= '0;
            desc_len_q     <= '0;
            desc_valid_q   <= 1'b0;
            req_ready_q    <= 1'b0;
            status_valid_q <= 1'b0;
            status_tag_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            remaining_q    <= remaining_d;
            outstanding_q  <= outstanding_d;
            tag_q          <= tag_d;
            id_q           <= id_d;
            dest_q         <= dest_d;
            user_q         <= user_d;
            desc_addr_q    <= desc_addr_d;
            desc_len_q     <= desc_len_d;
            desc_valid_q   <= desc_valid_d;
            req_ready_q    <= req_ready_d;
            status_valid_q <= status_valid_d;
            status_tag_q   <= status_tag_d;
            busy_q         <= busy_d;
        end
    end

    assign s_axis_req_ready        = req_ready_q;
    assign m_axis_read_desc_addr   = desc_addr_q;
    assign m_axis_read_desc_len    = desc_len_q;
    assign m_axis_read_desc_tag    = tag_q;
    assign m_axis_read_desc_id     = id_q;
    assign m_axis_read_desc_dest   = dest_q;
    assign m_axis_read_desc_user   = user_q;
    assign m_axis_read_desc_valid  = desc_valid_q;
    assign m_axis_req_status_tag   = status_tag_q;
    assign m_axis_req_status_valid = status_valid_q;
    assign busy                    = busy_q;

endmodule

// File: tb/tb_axi_dma_rd_desc_split.sv
// Scoreboard bench for axi_dma_rd_desc_split: requests push their expected
// descriptor list and parent status; a negedge monitor pops and compares.
module tb_axi_dma_rd_desc_split;

    localparam int unsigned AW = 16, LW = 20, TW = 8, IW = 8, DW = 8, UW = 1;
    localparam int unsigned CHUNK = 256, MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len  = '0;
    logic [TW-1:0] req_tag  = '0;
    logic [IW-1:0] req_id   = '0;
    logic [DW-1:0] req_dest = '0;
    logic [UW-1:0] req_user = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;

    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_len;
    logic [TW-1:0] d_tag;
    logic [IW-1:0] d_id;
    logic [DW-1:0] d_dest;
    logic [UW-1:0] d_user;
    logic          d_valid;
    logic          d_ready = 1'b0;

    logic [TW-1:0] st_tag   = '0;
    logic          st_valid = 1'b0;
    logic [TW-1:0] rs_tag;
    logic          rs_valid;
    logic          busy;

    axi_dma_rd_desc_split #(
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
        .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW), .AXIS_USER_WIDTH(UW),
        .CHUNK_SIZE(CHUNK), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_req_addr(req_addr), .s_axis_req_len(req_len), .s_axis_req_tag(req_tag),
        .s_axis_req_id(req_id), .s_axis_req_dest(req_dest), .s_axis_req_user(req_user),
        .s_axis_req_valid(req_valid), .s_axis_req_ready(req_ready),
        .m_axis_read_desc_addr(d_addr), .m_axis_read_desc_len(d_len),
        .m_axis_read_desc_tag(d_tag), .m_axis_read_desc_id(d_id),
        .m_axis_read_desc_dest(d_dest), .m_axis_read_desc_user(d_user),
        .m_axis_read_desc_valid(d_valid), .m_axis_read_desc_ready(d_ready),
        .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_valid(st_valid),
        .m_axis_req_status_tag(rs_tag), .m_axis_req_status_valid(rs_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [TW-1:0] tag;
        logic [IW-1:0] id;
        logic [DW-1:0] dest;
        logic [UW-1:0] user;
    } desc_t;

    desc_t         exp_desc[$];
    logic [TW-1:0] exp_stat[$];

    int n_checks = 0, n_fail = 0;
    int pending = 0, tb_out = 0, desc_seen = 0, inject = 0, grant = 0;
    int stat_mode = 0;   // 0: random completion delay, 1: only on grant
    int rdy_mode  = 0;   // 0: random, 1: always high, 2: always low
    int stat_cyc = -1, first_rise = -1, accept_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference split: walk the byte range, cutting at every CHUNK boundary
    task automatic model_req(input int unsigned addr, input int unsigned len,
                             input logic [TW-1:0] tag, input logic [IW-1:0] id,
                             input logic [DW-1:0] dest, input logic [UW-1:0] user);
        int unsigned a, r, room, c;
        desc_t d;
        a = addr;
        r = len;
        while (r > 0) begin
            room = CHUNK - (a % CHUNK);
            c = (r < room) ? r : room;
            d.addr = AW'(a); d.len = LW'(c); d.tag = tag; d.id = id; d.dest = dest; d.user = user;
            exp_desc.push_back(d);
            a = (a + c) % (1 << AW);
            r = r - c;
        end
        exp_stat.push_back(tag);
    endtask

    // Monitor / scoreboard
    desc_t mon_cur, mon_prev, mon_exp;
    logic  prev_hold = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            mon_cur = {d_addr, d_len, d_tag, d_id, d_dest, d_user};
            if (prev_hold) check("desc_stable_under_backpressure", {d_valid, mon_cur}, {1'b1, mon_prev});
            if (d_valid && first_rise < 0) first_rise = cyc;
            prev_hold = d_valid && !d_ready;
            mon_prev  = mon_cur;
            if (d_valid && d_ready) begin
                if (exp_desc.size() == 0) begin
                    fail_now("unexpected_desc");
                end else begin
                    mon_exp = exp_desc.pop_front();
                    check("desc_fields", mon_cur, mon_exp);
                end
                tb_out++;
                pending++;
                desc_seen++;
                check("outstanding_bound", tb_out <= int'(MAXO), 1'b1);
            end
            if (st_valid && tb_out > 0) tb_out--;
            if (rs_valid) begin
                stat_cyc = cyc;
                if (exp_stat.size() == 0) fail_now("unexpected_parent_status");
                else check("parent_status_tag", rs_tag, exp_stat.pop_front());
                check("parent_status_after_all_done", {exp_desc.size() == 0, tb_out == 0}, 2'b11);
            end
        end
    end

    // Downstream ready and completion driver
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       d_ready = ($urandom_range(0, 3) != 0);
            1:       d_ready = 1'b1;
            default: d_ready = 1'b0;
        endcase
        st_valid = 1'b0;
        st_tag   = TW'($urandom);
        if (inject > 0) begin
            st_valid = 1'b1;
            inject--;
        end else if (pending > 0) begin
            if (stat_mode == 0 && $urandom_range(0, 1) == 0) begin
                st_valid = 1'b1;
                pending--;
            end else if (stat_mode == 1 && grant > 0) begin
                st_valid = 1'b1;
                pending--;
                grant--;
            end
        end
    end

    task automatic all_zero_check(input string name);
        check(name, {req_ready, d_addr, d_len, d_tag, d_id, d_dest, d_user, d_valid,
                     rs_tag, rs_valid, busy}, '0);
    endtask

    // Asynchronous reset mid-cycle, scoreboard flushed, then released
    task automatic do_reset(input string name);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        all_zero_check({name, "_outputs_zero"});
        exp_desc.delete();
        exp_stat.delete();
        pending = 0; tb_out = 0; grant = 0; inject = 0;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_ready_low_in_reset"}, req_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_ready_after_release"}, req_ready, 1'b1);
    endtask

    task automatic send_req(input int unsigned addr, input int unsigned len,
                            input logic [TW-1:0] tag, input logic [IW-1:0] id,
                            input logic [DW-1:0] dest, input logic [UW-1:0] user);
        int t;
        t = 0;
        first_rise = -1;
        stat_cyc   = -1;
        desc_seen  = 0;
        model_req(addr, len, tag, id, dest, user);
        req_addr = AW'(addr); req_len = LW'(len); req_tag = tag;
        req_id = id; req_dest = dest; req_user = user;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            fail_now("request_accept_timeout");
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        accept_cyc = cyc;
        check("busy_not_ready_after_accept", {busy, req_ready}, 2'b10);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_stat.size() != 0 || busy) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) begin
            fail_now({name, "_completion_timeout"});
            do_reset({name, "_recover"});
        end else begin
            check({name, "_idle_after_done"}, {busy, req_ready}, 2'b01);
        end
    endtask

    initial begin
        int unsigned a, l, k;

        #2 rst = 1'b0;
        #1 all_zero_check("reset_outputs_zero");
        repeat (2) @(posedge clk);
        #1;
        check("ready_low_during_reset", req_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_high_after_release", req_ready, 1'b1);

        // Aligned split with prompt completions
        rdy_mode = 1; stat_mode = 0;
        send_req(32'h0000, 1024, 8'd3, 8'h11, 8'h22, 1'b1);
        wait_idle("aligned");
        check("aligned_desc_count", desc_seen, 4);
        check("aligned_first_desc_latency", first_rise, accept_cyc + 1);

        // Unaligned split
        rdy_mode = 0;
        send_req(32'h00F0, 32'h120, 8'd7, 8'h01, 8'h02, 1'b0);
        wait_idle("unaligned");
        check("unaligned_desc_count", desc_seen, 3);

        // Zero length: no descriptor, status one cycle after accept
        send_req(32'h1234, 0, 8'd5, 8'h00, 8'h00, 1'b0);
        wait_idle("zero_len");
        check("zero_len_desc_count", desc_seen, 0);
        check("zero_len_status_latency", stat_cyc, accept_cyc + 1);

        // Outstanding limit with completions withheld
        rdy_mode = 1; stat_mode = 1; grant = 0;
        send_req(32'h0400, 1024, 8'd9, 8'h33, 8'h44, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("limit_stall_at_max", desc_seen, 2);
        grant = 1;
        repeat (10) @(posedge clk);
        #1;
        check("limit_release_one", desc_seen, 3);
        grant = 1;
        repeat (10) @(posedge clk);
        #1;
        check("limit_release_two", desc_seen, 4);
        check("limit_no_early_status", stat_cyc, -1);
        grant = 2;
        wait_idle("limit");
        stat_mode = 0;

        // Backpressure: hold ready low, fields must stay put
        rdy_mode = 2;
        send_req(32'h0030, 32'h300, 8'h11, 8'h55, 8'h66, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("backpressure_valid_held", d_valid, 1'b1);
        rdy_mode = 0;
        wait_idle("backpressure");
        check("backpressure_desc_count", desc_seen, 4);

        // Address wrap past 0xFFFF
        send_req(32'hFF80, 32'h100, 8'h12, 8'h77, 8'h88, 1'b1);
        wait_idle("wrap");
        check("wrap_desc_count", desc_seen, 2);

        // Reset mid-request, late completions, then a clean request
        rdy_mode = 1; stat_mode = 1; grant = 0;
        send_req(32'h2000, 32'h400, 8'h21, 8'h01, 8'h01, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_desc_count", desc_seen, 2);
        do_reset("mid_reset");
        stat_mode = 0;
        inject = 2;
        repeat (5) @(posedge clk);
        #1;
        check("late_status_ignored_idle", {busy, rs_valid}, 2'b00);
        send_req(32'h0000, 32'h200, 8'h22, 8'h02, 8'h03, 1'b1);
        wait_idle("after_reset");
        check("after_reset_desc_count", desc_seen, 2);

        // Randomized requests, including boundary-hitting lengths
        rdy_mode = 0; stat_mode = 0;
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 65535);
            k = $urandom_range(0, 9);
            if (k == 0)      l = 0;
            else if (k < 4)  l = $urandom_range(1, 16);
            else if (k < 6)  l = CHUNK - (a % CHUNK) + $urandom_range(0, 2);
            else             l = $urandom_range(1, 1500);
            send_req(a, l, TW'($urandom), IW'($urandom), DW'($urandom), UW'($urandom));
            wait_idle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_dma_rd_desc_split.md
Name: axi_dma_rd_desc_split

Overview:
- Sits directly upstream of axi_dma_rd. Accepts one large read request (addr, len, tag, id, dest, user).
- Splits the request into read descriptors that never cross a CHUNK_SIZE-aligned address boundary and issues them in order to axi_dma_rd.
- Counts axi_dma_rd completion statuses and emits a single status for the parent request once every sub-descriptor has completed.
- Bounds in-flight descriptors to MAX_OUTSTANDING so downstream buffering stays fixed.

Parameters:
- ADDR_WIDTH, 16, address width; matches AXI_ADDR_WIDTH of axi_dma_rd.
- LEN_WIDTH, 20, byte length width of request and descriptor.
- TAG_WIDTH, 8, tag width.
- AXIS_ID_WIDTH, 8, id field width.
- AXIS_DEST_WIDTH, 8, dest field width.
- AXIS_USER_WIDTH, 1, user field width.
- CHUNK_SIZE, 256, max bytes per descriptor; power of 2, at most 2**ADDR_WIDTH and at most 2**LEN_WIDTH-1.
- MAX_OUTSTANDING, 4, max issued-but-uncompleted descriptors; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- s_axis_req_addr  in  ADDR_WIDTH  request start byte address
- s_axis_req_len  in  LEN_WIDTH  request byte length
- s_axis_req_tag  in  TAG_WIDTH  request tag
- s_axis_req_id  in  AXIS_ID_WIDTH  passed to every sub-descriptor
- s_axis_req_dest  in  AXIS_DEST_WIDTH  passed through
- s_axis_req_user  in  AXIS_USER_WIDTH  passed through
- s_axis_req_valid  in  1  request valid
- s_axis_req_ready  out  1  request accepted when valid&ready
- m_axis_read_desc_addr  out  ADDR_WIDTH  sub-descriptor address
- m_axis_read_desc_len  out  LEN_WIDTH  sub-descriptor length
- m_axis_read_desc_tag  out  TAG_WIDTH  parent tag
- m_axis_read_desc_id  out  AXIS_ID_WIDTH  parent id
- m_axis_read_desc_dest  out  AXIS_DEST_WIDTH  parent dest
- m_axis_read_desc_user  out  AXIS_USER_WIDTH  parent user
- m_axis_read_desc_valid  out  1  descriptor valid
- m_axis_read_desc_ready  in  1  axi_dma_rd ready
- s_axis_read_desc_status_tag  in  TAG_WIDTH  completion tag from axi_dma_rd (not checked)
- s_axis_read_desc_status_valid  in  1  one completion per cycle asserted
- m_axis_req_status_tag  out  TAG_WIDTH  parent completion tag
- m_axis_req_status_valid  out  1  single-cycle completion pulse, no ready
- busy  out  1  high whenever a request is in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, except s_axis_req_ready, which is 0 during reset and 1 from the first clock edge after release.
- Registers: cur_addr, remaining, outstanding (0..MAX_OUTSTANDING).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - ready=1.
  - On handshake: latch all fields; cur_addr=addr; remaining=len.
  - len==0 -> DONE; otherwise -> ISSUE.
- ISSUE:
  - chunk = min(remaining, CHUNK_SIZE - (cur_addr mod CHUNK_SIZE)).
  - If valid=0 and outstanding<MAX_OUTSTANDING: load addr=cur_addr, len=chunk, valid=1 (first descriptor valid on cycle N+1 after accept at N).
  - Descriptor fields stay stable while valid && !ready.
  - On desc handshake:
    - cur_addr += chunk, modulo 2**ADDR_WIDTH (wrap allowed).
    - remaining -= chunk.
    - valid drops for one cycle; back-to-back issue is not required.
    - If remaining==chunk (last piece) -> WAIT.
  - Stall: no new descriptor while outstanding==MAX_OUTSTANDING.
- Outstanding count:
  - +1 on desc handshake, -1 on status_valid.
  - Both in the same cycle -> unchanged.
  - status_valid with outstanding==0 is ignored; count saturates at 0.
- WAIT: when outstanding==0 (including a decrement to 0 this cycle) -> DONE.
- DONE:
  - Pulse m_axis_req_status_valid=1 for exactly one cycle with the parent tag; -> IDLE.
  - For len==0, the pulse lands on cycle N+1 after accept.
- Only one parent request in flight; s_axis_req_ready=0 outside IDLE.
- Reset mid-operation:
  - Descriptors already issued are abandoned; no status is emitted for them.
  - Late statuses arriving afterwards are ignored because outstanding==0.

Test Plan:
- Aligned split: addr=0x0000, len=1024, tag=3, ready=1, statuses returned after each descriptor -> 4 descs (0x000,256), (0x100,256), (0x200,256), (0x300,256), all tag 3; status tag 3 pulses once after the 4th completion.
- Unaligned split: addr=0x00F0, len=0x120 -> descs (0x00F0,0x10), (0x0100,0x100), (0x0200,0x10); single parent status.
- Zero length: len=0, tag=5 -> no descriptor; status_valid=1 tag 5 for exactly one cycle, 1 cycle after accept; busy back to 0.
- Outstanding limit: MAX_OUTSTANDING=2, len=1024, statuses withheld -> exactly 2 descs issued, then stall. Each status releases one more. Parent status only after the 4th status.
- Backpressure and simultaneous events: hold m_axis_read_desc_ready=0 for 5 cycles -> descriptor fields stable. A status arriving in the same cycle as a desc handshake leaves outstanding unchanged.
- Wrap and reset: addr=0xFF80, len=0x100 -> descs (0xFF80,0x80), (0x0000,0x80). Then assert rst mid-request -> all outputs 0 immediately; the next request after release completes normally.
